// File: rtl/video_timing_gen_if.sv
// Configuration port of video_timing_gen: one timing word per valid/ready
// transfer, plus a one-cycle rejection pulse back to the sender.
interface video_timing_gen_if #(
    parameter int H_W = 12,
    parameter int V_W = 12
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [H_W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [V_W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic           cfg_h_pol, cfg_v_pol;
    logic           cfg_err;

    modport master (
        output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_pol, cfg_v_pol,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_pol, cfg_v_pol,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: early pixel coordinates for upstream
// sources, de/syncs delayed so a PIPE_DELAY-deep pixel pipeline lines up.
module video_timing_gen #(
    parameter int H_W          = 12,
    parameter int V_W          = 12,
    parameter int PIPE_DELAY   = 2,
    parameter int DEF_H_ACTIVE = 640,
    parameter int DEF_H_FP     = 16,
    parameter int DEF_H_SYNC   = 96,
    parameter int DEF_H_BP     = 48,
    parameter int DEF_V_ACTIVE = 480,
    parameter int DEF_V_FP     = 10,
    parameter int DEF_V_SYNC   = 2,
    parameter int DEF_V_BP     = 33
) (
    input  logic              pxl_clk,
    input  logic              rst_n,
    video_timing_gen_if.slave cfg,
    output logic              req,
    output logic [H_W-1:0]    cx,
    output logic [V_W-1:0]    cy,
    output logic              line_start,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int HX = H_W + 2;
    localparam int VX = V_W + 2;
    localparam logic [HX-1:0] H_LIM = {2'b01, {H_W{1'b0}}};
    localparam logic [VX-1:0] V_LIM = {2'b01, {V_W{1'b0}}};

    typedef struct packed {
        logic [H_W-1:0] ha, hf, hs, hb;
        logic [V_W-1:0] va, vf, vs, vb;
        logic           hp, vp;
    } timing_t;

    typedef struct packed {
        logic de, hs, vs, fs;
    } dly_t;

    localparam timing_t DEF = '{
        ha: H_W'(DEF_H_ACTIVE), hf: H_W'(DEF_H_FP), hs: H_W'(DEF_H_SYNC), hb: H_W'(DEF_H_BP),
        va: V_W'(DEF_V_ACTIVE), vf: V_W'(DEF_V_FP), vs: V_W'(DEF_V_SYNC), vb: V_W'(DEF_V_BP),
        hp: 1'b0, vp: 1'b0
    };
    localparam dly_t DLY_RST = '{de: 1'b0, hs: ~DEF.hp, vs: ~DEF.vp, fs: 1'b0};

    timing_t        act, shd, cfg_w;
    logic           pending, err_q;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    dly_t [PIPE_DELAY:0] dly;

    assign cfg_w = '{
        ha: cfg.cfg_h_active, hf: cfg.cfg_h_fp, hs: cfg.cfg_h_sync, hb: cfg.cfg_h_bp,
        va: cfg.cfg_v_active, vf: cfg.cfg_v_fp, vs: cfg.cfg_v_sync, vb: cfg.cfg_v_bp,
        hp: cfg.cfg_h_pol, vp: cfg.cfg_v_pol
    };

    // Sums are kept two bits wider so oversize words can be detected, not wrapped.
    logic [HX-1:0] h_ext, h_sync_beg, h_sync_end, h_total, cfg_h_total;
    logic [VX-1:0] v_ext, v_sync_beg, v_sync_end, v_total, cfg_v_total;

    assign h_ext       = HX'(h);
    assign h_sync_beg  = HX'(act.ha) + HX'(act.hf);
    assign h_sync_end  = h_sync_beg + HX'(act.hs);
    assign h_total     = h_sync_end + HX'(act.hb);
    assign cfg_h_total = HX'(cfg_w.ha) + HX'(cfg_w.hf) + HX'(cfg_w.hs) + HX'(cfg_w.hb);

    assign v_ext       = VX'(v);
    assign v_sync_beg  = VX'(act.va) + VX'(act.vf);
    assign v_sync_end  = v_sync_beg + VX'(act.vs);
    assign v_total     = v_sync_end + VX'(act.vb);
    assign cfg_v_total = VX'(cfg_w.va) + VX'(cfg_w.vf) + VX'(cfg_w.vs) + VX'(cfg_w.vb);

    logic accept, cfg_ok, h_last, v_last;
    assign accept = cfg.cfg_valid && !pending;
    assign cfg_ok = (|cfg_w.ha) && (|cfg_w.hs) && (|cfg_w.va) && (|cfg_w.vs) &&
                    (cfg_h_total <= H_LIM) && (cfg_v_total <= V_LIM);
    assign h_last = h_ext == h_total - HX'(1);
    assign v_last = v_ext == v_total - VX'(1);

    assign cfg.cfg_ready = !pending;
    assign cfg.cfg_err   = err_q;

    // Stage 0: raster counters plus config shadow; the shadow only lands on the
    // last pixel of a frame so the current frame always completes unchanged.
    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            h       <= '0;
            v       <= '0;
            act     <= DEF;
            shd     <= DEF;
            pending <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                if (cfg_ok) begin
                    shd     <= cfg_w;
                    pending <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (h_last && v_last) begin
                h <= '0;
                v <= '0;
                if (pending) begin
                    act     <= shd;
                    pending <= 1'b0;
                end
            end else if (h_last) begin
                h <= '0;
                v <= v + V_W'(1);
            end else begin
                h <= h + H_W'(1);
            end
        end
    end

    logic h_act, v_act, hs_on, vs_on;
    assign h_act = h < act.ha;
    assign v_act = v < act.va;
    assign hs_on = (h_ext >= h_sync_beg) && (h_ext < h_sync_end);
    assign vs_on = (v_ext >= v_sync_beg) && (v_ext < v_sync_end);

    // Stage 1 decode; dly[0] is the same stage, dly[PIPE_DELAY] drives the outputs.
    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            req        <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            line_start <= 1'b0;
            dly        <= {(PIPE_DELAY+1){DLY_RST}};
        end else begin
            req        <= h_act && v_act;
            cx         <= (h_act && v_act) ? h : '0;
            cy         <= (h_act && v_act) ? v : '0;
            line_start <= (h == '0);
            dly[0]     <= '{de: h_act && v_act,
                            hs: hs_on ? act.hp : ~act.hp,
                            vs: vs_on ? act.vp : ~act.vp,
                            fs: (h == '0) && (v == '0)};
            for (int i = 1; i <= PIPE_DELAY; i++) dly[i] <= dly[i-1];
        end
    end

    assign de          = dly[PIPE_DELAY].de;
    assign hsync       = dly[PIPE_DELAY].hs;
    assign vsync       = dly[PIPE_DELAY].vs;
    assign frame_start = dly[PIPE_DELAY].fs;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a VIC 1 instance (long frames, directed config
// words) and a small-raster instance driven with random config traffic.
module tb_video_timing_gen;
    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } tm_t;

    typedef struct {
        bit req, ls, de, hs, vs, fs;
        int cx, cy;
    } st_t;

    logic pxl_clk = 1'b0;
    logic rst_n   = 1'b1;
    always #5 pxl_clk = ~pxl_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus words for instance 0 (a) and 1 (b).
    tm_t wrd [2];
    bit  wv  [2];

    video_timing_gen_if #(.H_W(12), .V_W(12)) ifa ();
    video_timing_gen_if #(.H_W(8),  .V_W(6))  ifb ();

    assign ifa.cfg_valid    = wv[0];
    assign ifa.cfg_h_active = 12'(wrd[0].ha);
    assign ifa.cfg_h_fp     = 12'(wrd[0].hf);
    assign ifa.cfg_h_sync   = 12'(wrd[0].hs);
    assign ifa.cfg_h_bp     = 12'(wrd[0].hb);
    assign ifa.cfg_v_active = 12'(wrd[0].va);
    assign ifa.cfg_v_fp     = 12'(wrd[0].vf);
    assign ifa.cfg_v_sync   = 12'(wrd[0].vs);
    assign ifa.cfg_v_bp     = 12'(wrd[0].vb);
    assign ifa.cfg_h_pol    = wrd[0].hp;
    assign ifa.cfg_v_pol    = wrd[0].vp;

    assign ifb.cfg_valid    = wv[1];
    assign ifb.cfg_h_active = 8'(wrd[1].ha);
    assign ifb.cfg_h_fp     = 8'(wrd[1].hf);
    assign ifb.cfg_h_sync   = 8'(wrd[1].hs);
    assign ifb.cfg_h_bp     = 8'(wrd[1].hb);
    assign ifb.cfg_v_active = 6'(wrd[1].va);
    assign ifb.cfg_v_fp     = 6'(wrd[1].vf);
    assign ifb.cfg_v_sync   = 6'(wrd[1].vs);
    assign ifb.cfg_v_bp     = 6'(wrd[1].vb);
    assign ifb.cfg_h_pol    = wrd[1].hp;
    assign ifb.cfg_v_pol    = wrd[1].vp;

    logic        a_req, a_ls, a_de, a_hs, a_vs, a_fs;
    logic [11:0] a_cx, a_cy;
    logic        b_req, b_ls, b_de, b_hs, b_vs, b_fs;
    logic [7:0]  b_cx;
    logic [5:0]  b_cy;

    video_timing_gen dut_a (
        .pxl_clk(pxl_clk), .rst_n(rst_n), .cfg(ifa),
        .req(a_req), .cx(a_cx), .cy(a_cy), .line_start(a_ls),
        .de(a_de), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
    );

    video_timing_gen #(
        .H_W(8), .V_W(6), .PIPE_DELAY(3),
        .DEF_H_ACTIVE(12), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_ACTIVE(5),  .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1)
    ) dut_b (
        .pxl_clk(pxl_clk), .rst_n(rst_n), .cfg(ifb),
        .req(b_req), .cx(b_cx), .cy(b_cy), .line_start(b_ls),
        .de(b_de), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
    );

    // Reference model: frame position as a single pixel index into the raster.
    tm_t def_t [2];
    int  hw [2], vw [2], pd [2];
    tm_t cur [2], shd [2];
    bit  pend [2], m_err [2], m_acc [2];
    int  pos [2];
    st_t hist [2][9];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int tot_h(input tm_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int tot_v(input tm_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    function automatic st_t decode(input tm_t t, input int p);
        st_t d;
        int  h, v;
        bit  a;
        h = p % tot_h(t);
        v = p / tot_h(t);
        a = (h < t.ha) && (v < t.va);
        d.req = a;
        d.de  = a;
        d.cx  = a ? h : 0;
        d.cy  = a ? v : 0;
        d.ls  = (h == 0);
        d.fs  = (p == 0);
        d.hs  = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.hp : !t.hp;
        d.vs  = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.vp : !t.vp;
        return d;
    endfunction

    task automatic model_reset(input int k);
        st_t r;
        r = '{req: 0, ls: 0, de: 0, hs: !def_t[k].hp, vs: !def_t[k].vp, fs: 0, cx: 0, cy: 0};
        cur[k]   = def_t[k];
        pend[k]  = 0;
        m_err[k] = 0;
        m_acc[k] = 0;
        pos[k]   = 0;
        for (int i = 0; i < 9; i++) hist[k][i] = r;
    endtask

    task automatic model_step(input int k);
        bit pp, last, ok;
        tm_t w;
        for (int i = 8; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = decode(cur[k], pos[k]);
        pp   = pend[k];
        last = pos[k] == tot_h(cur[k]) * tot_v(cur[k]) - 1;
        w    = wrd[k];
        ok   = w.ha > 0 && w.hs > 0 && w.va > 0 && w.vs > 0 &&
               tot_h(w) <= (1 << hw[k]) && tot_v(w) <= (1 << vw[k]);
        m_err[k] = 0;
        m_acc[k] = wv[k] && !pp;
        if (m_acc[k]) begin
            if (ok) begin
                shd[k]  = w;
                pend[k] = 1;
            end else begin
                m_err[k] = 1;
            end
        end
        if (last) begin
            pos[k] = 0;
            if (pp) begin
                cur[k]  = shd[k];
                pend[k] = 0;
            end
        end else begin
            pos[k]++;
        end
    endtask

    task automatic check_dut(input int k);
        st_t s1, sd;
        logic [7:0] exp_c;
        s1 = hist[k][0];
        sd = hist[k][pd[k]];
        exp_c = {s1.req, s1.ls, sd.de, sd.hs, sd.vs, sd.fs, !pend[k], m_err[k]};
        if (k == 0) begin
            chk("a_ctl", {a_req, a_ls, a_de, a_hs, a_vs, a_fs, ifa.cfg_ready, ifa.cfg_err}, exp_c);
            chk("a_cx", a_cx, s1.cx);
            chk("a_cy", a_cy, s1.cy);
        end else begin
            chk("b_ctl", {b_req, b_ls, b_de, b_hs, b_vs, b_fs, ifb.cfg_ready, ifb.cfg_err}, exp_c);
            chk("b_cx", b_cx, s1.cx);
            chk("b_cy", b_cy, s1.cy);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge pxl_clk);
        #1;
        for (int k = 0; k < 2; k++) check_dut(k);
        @(negedge pxl_clk);
    endtask

    // Small-raster words, with exact-limit, over-limit and zero-field cases mixed in.
    function automatic tm_t rand_word();
        tm_t t;
        int  m;
        m = $urandom_range(0, 15);
        t = '{ha: $urandom_range(1, 20), hf: $urandom_range(0, 4), hs: $urandom_range(1, 4),
              hb: $urandom_range(0, 4),  va: $urandom_range(1, 6), vf: $urandom_range(0, 2),
              vs: $urandom_range(1, 2),  vb: $urandom_range(0, 2),
              hp: 1'($urandom_range(0, 1)), vp: 1'($urandom_range(0, 1))};
        case (m)
            0, 1: begin
                t.ha = 200; t.hf = 20; t.hs = 20; t.hb = (m == 0) ? 16 : 17;
                t.va = 1; t.vf = 0; t.vs = 1; t.vb = 0;
            end
            2, 3: begin
                t.ha = 1; t.hf = 0; t.hs = 1; t.hb = 0;
                t.va = 40; t.vf = 10; t.vs = 4; t.vb = (m == 2) ? 10 : 11;
            end
            4: t.ha = 0;
            5: t.hs = 0;
            6: t.va = 0;
            7: t.vs = 0;
            default: ;
        endcase
        return t;
    endfunction

    task automatic send_a(input tm_t t, input int hold);
        wrd[0] = t;
        wv[0]  = 1;
        repeat (hold) tick();
        wv[0]  = 0;
    endtask

    initial begin
        def_t[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 0, vp: 0};
        def_t[1] = '{ha: 12, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 1, vb: 1, hp: 0, vp: 0};
        hw = '{12, 8};
        vw = '{12, 6};
        pd = '{2, 3};
        wrd[0] = def_t[0];
        wrd[1] = def_t[1];
        wv = '{0, 0};

        #1 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge pxl_clk);
        rst_n = 1'b1;

        // Default raster: a few VIC 1 lines, many small frames on b.
        repeat (2000) tick();

        // Rejections, the exact 4096-wide limit, then a stalled second word.
        send_a('{ha: 640, hf: 16, hs: 0, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 0, vp: 0}, 1);
        repeat (3) tick();
        send_a('{ha: 3840, hf: 176, hs: 40, hb: 41, va: 2160, vf: 8, vs: 10, vb: 72, hp: 1, vp: 1}, 1);
        repeat (3) tick();
        send_a('{ha: 3840, hf: 176, hs: 40, hb: 40, va: 2160, vf: 8, vs: 10, vb: 72, hp: 1, vp: 1}, 1);
        repeat (3) tick();
        send_a('{ha: 1280, hf: 110, hs: 40, hb: 220, va: 720, vf: 5, vs: 5, vb: 20, hp: 1, vp: 1}, 50);

        // Random config traffic on the small raster; a word is held until taken.
        repeat (40000) begin
            if (!wv[1] && $urandom_range(0, 29) == 0) begin
                wrd[1] = rand_word();
                wv[1]  = 1;
            end
            tick();
            if (m_acc[1]) wv[1] = 0;
        end

        // Asynchronous reset away from any clock edge, with a word pending on a.
        #2 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        wv = '{0, 0};
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge pxl_clk);
        rst_n = 1'b1;
        repeat (1700) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
